// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit holding the architectural HI/LO registers.
// Signed operands are reduced to magnitudes up front and the sign is restored in a final cycle.
module muldiv_unit #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNTW  = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] srca,
  input  logic [WIDTH-1:0] srcb,
  input  logic             mthi,
  input  logic             mtlo,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t             state_q, state_d;
  logic               is_div_q, is_div_d;
  logic [CNTW-1:0]    cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic               neg_res_q, neg_res_d;
  logic               neg_rem_q, neg_rem_d;
  logic               div0_q, div0_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic               busy_q, busy_d, done_q, done_d;

  logic               is_signed;
  logic [WIDTH-1:0]   abs_a, abs_b;
  logic [WIDTH:0]     add_sum, trial;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot_fix, rem_fix;

  always_comb begin
    is_signed = ~op[0];
    abs_a     = (is_signed && srca[WIDTH-1]) ? -srca : srca;
    abs_b     = (is_signed && srcb[WIDTH-1]) ? -srcb : srcb;
    // acc holds {partial product, multiplier} for multiply and {remainder, quotient} for divide
    add_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    trial     = acc_q[2*WIDTH-1:WIDTH-1] - {1'b0, opnd_q};
    prod_fix  = neg_res_q ? -acc_q : acc_q;
    quot_fix  = div0_q ? '1 : (neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0]);
    rem_fix   = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
  end

  always_comb begin
    state_d   = state_q;
    is_div_d  = is_div_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    opnd_d    = opnd_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    div0_d    = div0_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          is_div_d  = op[1];
          opnd_d    = op[1] ? abs_b : abs_a;
          acc_d     = {{WIDTH{1'b0}}, (op[1] ? abs_a : abs_b)};
          neg_res_d = is_signed & (srca[WIDTH-1] ^ srcb[WIDTH-1]);
          neg_rem_d = is_signed & srca[WIDTH-1];
          div0_d    = (srcb == '0);
          cnt_d     = '0;
          busy_d    = 1'b1;
          state_d   = RUN;
        end else begin
          if (mthi) hi_d = srca;
          if (mtlo) lo_d = srca;
        end
      end
      RUN: begin
        if (is_div_q) begin
          // Restoring step: keep the subtraction only when it does not borrow
          acc_d = trial[WIDTH] ? {acc_q[2*WIDTH-2:0], 1'b0}
                               : {trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
        end else begin
          acc_d = {add_sum, acc_q[WIDTH-1:1]};
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNTW'(WIDTH - 1)) state_d = FIN;
      end
      FIN: begin
        if (is_div_q) begin
          hi_d = rem_fix;
          lo_d = quot_fix;
        end else begin
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      is_div_q  <= 1'b0;
      cnt_q     <= '0;
      acc_q     <= '0;
      opnd_q    <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      div0_q    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      is_div_q  <= is_div_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      opnd_q    <= opnd_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      div0_q    <= div0_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: expected {hi,lo} is queued at start and checked at done.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] srca, srcb;
  logic        mthi, mtlo;
  logic        busy, done;
  logic [31:0] hi, lo;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  logic [63:0] exp_q[$];

  muldiv_unit #(.WIDTH(32), .CNTW(6)) dut (
    .clk  (clk),
    .reset(reset),
    .start(start),
    .op   (op),
    .srca (srca),
    .srcb (srcb),
    .mthi (mthi),
    .mtlo (mtlo),
    .busy (busy),
    .done (done),
    .hi   (hi),
    .lo   (lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    logic [63:0] r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (o)
      2'b00: r = 64'(sa * sb);
      2'b01: r = {32'b0, a} * {32'b0, b};
      default: begin
        if (b == 32'b0)      r = {a, 32'hFFFF_FFFF};
        else if (o == 2'b10) r = {32'(sa % sb), 32'(sa / sb)};
        else                 r = {a % b, a / b};
      end
    endcase
    return r;
  endfunction

  // mode 1: start/mthi/mtlo pulse at busy cycle 10; mode 2: mthi/mtlo coincident with start
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, input int mode);
    int unsigned cyc;
    logic [63:0] pre, e;
    @(negedge clk);
    pre   = {hi, lo};
    start = 1'b1;
    op    = o;
    srca  = a;
    srcb  = b;
    mthi  = (mode == 2);
    mtlo  = (mode == 2);
    exp_q.push_back(model(o, a, b));
    @(negedge clk);
    cyc = 0;
    while (!done && cyc < 100) begin
      if (busy) cyc++;
      if (cyc == 20) chk("hold", {hi, lo}, pre);
      start = (mode == 1 && cyc == 10);
      mthi  = start;
      mtlo  = start;
      srca  = $urandom;
      srcb  = $urandom;
      @(negedge clk);
    end
    start = 1'b0;
    mthi  = 1'b0;
    mtlo  = 1'b0;
    chk("latency", 64'(cyc), 64'd33);
    chk("busy_at_done", {63'b0, busy}, 64'd0);
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 64'hDEAD;
    chk($sformatf("result op%0d %h %h", o, a, b), {hi, lo}, e);
    @(negedge clk);
    chk("done_pulse", {63'b0, done}, 64'd0);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    op    = 2'b00;
    srca  = '0;
    srcb  = '0;
    mthi  = 1'b0;
    mtlo  = 1'b0;
    #1;
    chk("reset_state", {60'b0, busy, done, |hi, |lo}, 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    run_op(2'b00, 32'hFFFF_FFFD, 32'h0000_0005, 0);
    run_op(2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 0);
    run_op(2'b11, 32'h0000_0064, 32'h0000_0007, 0);
    run_op(2'b11, 32'h0000_0005, 32'h0000_0000, 0);
    run_op(2'b10, 32'hFFFF_FFF0, 32'h0000_0000, 0);
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op(2'b00, 32'h8000_0000, 32'h8000_0000, 0);
    run_op(2'b10, 32'h0000_0007, 32'hFFFF_FFFE, 0);

    // MTHI then MTLO, single-cycle pulses in IDLE
    @(negedge clk);
    mthi = 1'b1;
    srca = 32'hAAAA_BBBB;
    @(negedge clk);
    mthi = 1'b0;
    chk("mthi", {32'b0, hi}, 64'hAAAA_BBBB);
    mtlo = 1'b1;
    srca = 32'hBBBB_AAAA;
    @(negedge clk);
    mtlo = 1'b0;
    chk("mtlo", {hi, lo}, 64'hAAAA_BBBB_BBBB_AAAA);
    mthi = 1'b1;
    mtlo = 1'b1;
    srca = 32'h1234_5678;
    @(negedge clk);
    mthi = 1'b0;
    mtlo = 1'b0;
    chk("mt_both", {hi, lo}, 64'h1234_5678_1234_5678);

    run_op(2'b01, 32'd2, 32'd3, 1);
    run_op(2'b01, 32'd9, 32'd9, 2);

    // Asynchronous reset in the middle of a DIVU
    @(negedge clk);
    start = 1'b1;
    op    = 2'b11;
    srca  = 32'd1000;
    srcb  = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (14) @(negedge clk);
    chk("busy_before_abort", {63'b0, busy}, 64'd1);
    reset = 1'b1;
    #1;
    chk("abort_flags", {62'b0, busy, done}, 64'd0);
    chk("abort_hilo", {hi, lo}, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    run_op(2'b01, 32'd7, 32'd6, 0);

    for (int i = 0; i < 8; i++) begin
      logic [31:0] rb;
      rb = (i == 3) ? 32'b0 : $urandom;
      run_op(2'($urandom_range(0, 3)), $urandom, rb, 0);
    end

    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative multiply/divide unit for MULT, MULTU, DIV and DIVU, with the architectural HI/LO registers.
- Sits directly downstream of the register file: srca/srcb are rd1/rd2 (rs/rt), and HI/LO feed the writeback mux for MFHI/MFLO.
- Runs as a multi-cycle side unit; control stalls the core while busy is high.
- Also services MTHI/MTLO writes.

Parameters:
- WIDTH, 32, operand and HI/LO width.
- CNTW, 6, iteration counter width; must hold WIDTH+1.

Ports:
- clk  input  1  core clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- start  input  1  begin operation; sampled only in IDLE.
- op  input  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- srca  input  WIDTH  rs operand (regfile rd1); multiplicand, dividend, or MTHI/MTLO data.
- srcb  input  WIDTH  rt operand (regfile rd2); multiplier or divisor.
- mthi  input  1  write srca to HI.
- mtlo  input  1  write srca to LO.
- busy  output  1  operation in progress.
- done  output  1  one-cycle pulse: HI/LO have just been updated by an operation.
- hi  output  WIDTH  HI register.
- lo  output  WIDTH  LO register.

Behaviour:
- Reset (asynchronous, any time, including mid-operation):
  - Operation is aborted.
  - State=IDLE, hi=0, lo=0, busy=0, done=0, counter=0.
- States: IDLE, RUN, FIN.
- IDLE:
  - start=1 at edge E0: latch op, take |srca| and |srcb| (signed ops; WIDTH-bit unsigned magnitudes, so -2^31 maps to 0x8000_0000), record result signs, clear the accumulator, go to RUN, busy=1.
  - mthi/mtlo=1 with start=0: the selected register(s) load srca at that edge. Both high loads both.
  - start has priority: a coincident mthi/mtlo is ignored.
- RUN: one iteration per edge, E1..E32 (counter 0..WIDTH-1).
  - Multiply: radix-2 shift-add, 64-bit product.
  - Divide: restoring shift-subtract; quotient in the low half, remainder in the high half.
  - After the 32nd iteration go to FIN.
- FIN (edge E33):
  - Apply sign fixups.
  - Multiply: negate the 64-bit product if the operand signs differ.
  - Divide: negate the quotient if the signs differ; the remainder takes the dividend's sign.
  - Write hi/lo: product[63:32]/[31:0], or remainder/quotient.
  - busy=0, done=1 for exactly the cycle after E33, then IDLE.
- Latency: start accepted at E0 → results visible after E33; busy high from after E0 through E33.
- While busy: start, mthi and mtlo are ignored; hi/lo hold their old values until E33.
- Operands are latched at E0; later changes on srca/srcb have no effect.
- Divide by zero: lo=FFFF_FFFF, hi=srca, for both DIV and DIVU, regardless of sign. Still 33-cycle latency.
- DIV 8000_0000 / FFFF_FFFF: lo=8000_0000, hi=0.
- Unsigned ops never apply fixups.
- done is never high in the same cycle as busy.

Test Plan:
- Reset, then MULTU srca=FFFF_FFFF srcb=FFFF_FFFF → busy for 33 cycles, done pulse, hi=FFFF_FFFE, lo=0000_0001.
- MULT srca=FFFF_FFFD (-3) srcb=0000_0005 → hi=FFFF_FFFF, lo=FFFF_FFF1; then DIV srca=FFFF_FFF9 (-7) srcb=0000_0002 → lo=FFFF_FFFD, hi=FFFF_FFFF.
- DIVU srca=0000_0064 srcb=0000_0007 → lo=0000_000E, hi=0000_0002; then DIVU srca=0000_0005 srcb=0 → lo=FFFF_FFFF, hi=0000_0005.
- MTHI srca=AAAA_BBBB, then MTLO srca=BBBB_AAAA, each a single-cycle pulse in IDLE → hi=AAAA_BBBB, lo=BBBB_AAAA next cycle.
- Start MULTU 2×3, pulse start=1 and mthi=1 at cycle 10 of RUN → ignored; result hi=0, lo=6 at E33.
- Start DIVU, assert reset at cycle 15 → immediately busy=0, done=0, hi=lo=0; a following MULTU 7×6 gives lo=0000_002A.
